// File: rtl/udp_rx_filter.sv
// Receive-side Ethernet/IPv4/UDP filter: checks header fields against the local
// MAC/IP/port, verifies the IPv4 header checksum and forwards the UDP payload.
module udp_rx_filter #(
  parameter logic [47:0] MY_MAC  = 48'h123456789ABC,
  parameter logic [31:0] MY_IP   = {8'd192, 8'd168, 8'd1, 8'd44},
  parameter logic [15:0] MY_PORT = 16'd8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_last,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic        frame_ok,
  output logic        frame_drop
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        mac_uc_q, mac_uc_d;
  logic        mac_bc_q, mac_bc_d;
  logic [16:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic [31:0] ip_sh_q, ip_sh_d;
  logic [15:0] port_sh_q, port_sh_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_valid_q, pl_valid_d;
  logic        pl_last_q, pl_last_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_drop_q, frame_drop_d;

  logic        fail;
  logic [7:0]  mac_byte;
  logic [7:0]  ip_byte;
  logic [16:0] csum_sum;
  logic [15:0] csum_fold;

  always_comb begin
    case (cnt_q[2:0])
      3'd0:    mac_byte = MY_MAC[47:40];
      3'd1:    mac_byte = MY_MAC[39:32];
      3'd2:    mac_byte = MY_MAC[31:24];
      3'd3:    mac_byte = MY_MAC[23:16];
      3'd4:    mac_byte = MY_MAC[15:8];
      default: mac_byte = MY_MAC[7:0];
    endcase
  end

  // Offsets 30..33 have low bits 10,11,00,01.
  always_comb begin
    case (cnt_q[1:0])
      2'd2:    ip_byte = MY_IP[31:24];
      2'd3:    ip_byte = MY_IP[23:16];
      2'd0:    ip_byte = MY_IP[15:8];
      default: ip_byte = MY_IP[7:0];
    endcase
  end

  assign csum_sum  = acc_q + {1'b0, hi_q, rx_data};
  assign csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mac_uc_d     = mac_uc_q;
    mac_bc_d     = mac_bc_q;
    acc_d        = acc_q;
    hi_d         = hi_q;
    ip_sh_d      = ip_sh_q;
    port_sh_d    = port_sh_q;
    len_d        = len_q;
    rem_d        = rem_q;
    pl_data_d    = pl_data_q;
    pl_valid_d   = 1'b0;
    pl_last_d    = 1'b0;
    src_ip_d     = src_ip_q;
    src_port_d   = src_port_q;
    frame_ok_d   = 1'b0;
    frame_drop_d = 1'b0;
    fail         = 1'b0;

    if (rx_valid && cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;

    if (rx_valid && rx_sof) begin
      // HDR and PAYLOAD frames are still unresolved; DRAIN already pulsed.
      if (state_q == HDR || state_q == PAYLOAD) frame_drop_d = 1'b1;
      state_d  = HDR;
      cnt_d    = 11'd1;
      mac_uc_d = (rx_data == MY_MAC[47:40]);
      mac_bc_d = (rx_data == 8'hFF);
      acc_d    = '0;
      hi_d     = '0;
      len_d    = '0;
    end else if (rx_valid) begin
      case (state_q)
        HDR: begin
          if (cnt_q <= 11'd5) begin
            mac_uc_d = mac_uc_q && (rx_data == mac_byte);
            mac_bc_d = mac_bc_q && (rx_data == 8'hFF);
            if (cnt_q == 11'd5 && !mac_uc_d && !mac_bc_d) fail = 1'b1;
          end
          if (cnt_q == 11'd12 && rx_data != 8'h08) fail = 1'b1;
          if (cnt_q == 11'd13 && rx_data != 8'h00) fail = 1'b1;
          if (cnt_q == 11'd14 && rx_data != 8'h45) fail = 1'b1;
          if (cnt_q == 11'd20 && rx_data[5:0] != 6'd0) fail = 1'b1;
          if (cnt_q == 11'd21 && rx_data != 8'h00) fail = 1'b1;
          if (cnt_q == 11'd23 && rx_data != 8'h11) fail = 1'b1;
          if (cnt_q >= 11'd30 && cnt_q <= 11'd33 && rx_data != ip_byte) fail = 1'b1;
          if (cnt_q == 11'd36 && rx_data != MY_PORT[15:8]) fail = 1'b1;
          if (cnt_q == 11'd37 && rx_data != MY_PORT[7:0]) fail = 1'b1;
          if (cnt_q >= 11'd14 && cnt_q <= 11'd33) begin
            if (!cnt_q[0]) begin
              hi_d = rx_data;
            end else begin
              acc_d = {1'b0, csum_fold};
              if (cnt_q == 11'd33 && csum_fold != 16'hFFFF) fail = 1'b1;
            end
          end
          if (cnt_q >= 11'd26 && cnt_q <= 11'd29) ip_sh_d = {ip_sh_q[23:0], rx_data};
          if (cnt_q == 11'd34 || cnt_q == 11'd35) port_sh_d = {port_sh_q[7:0], rx_data};
          if (cnt_q == 11'd38) len_d = {rx_data, len_q[7:0]};
          if (cnt_q == 11'd39) begin
            len_d = {len_q[15:8], rx_data};
            if (len_d < 16'd8) fail = 1'b1;
          end

          if (fail) begin
            frame_drop_d = 1'b1;
            state_d      = rx_last ? IDLE : DRAIN;
          end else if (cnt_q == 11'd41) begin
            if (len_q == 16'd8) begin
              frame_ok_d = 1'b1;
              src_ip_d   = ip_sh_q;
              src_port_d = port_sh_q;
              state_d    = rx_last ? IDLE : DRAIN;
            end else if (rx_last) begin
              frame_drop_d = 1'b1;
              state_d      = IDLE;
            end else begin
              rem_d   = len_q - 16'd8;
              state_d = PAYLOAD;
            end
          end else if (rx_last) begin
            frame_drop_d = 1'b1;
            state_d      = IDLE;
          end
        end
        PAYLOAD: begin
          pl_data_d  = rx_data;
          pl_valid_d = 1'b1;
          rem_d      = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            pl_last_d  = 1'b1;
            frame_ok_d = 1'b1;
            src_ip_d   = ip_sh_q;
            src_port_d = port_sh_q;
            state_d    = rx_last ? IDLE : DRAIN;
          end else if (rx_last) begin
            pl_last_d    = 1'b1;
            frame_drop_d = 1'b1;
            state_d      = IDLE;
          end
        end
        DRAIN: begin
          if (rx_last) state_d = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mac_uc_q     <= 1'b0;
      mac_bc_q     <= 1'b0;
      acc_q        <= '0;
      hi_q         <= '0;
      ip_sh_q      <= '0;
      port_sh_q    <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      pl_data_q    <= '0;
      pl_valid_q   <= 1'b0;
      pl_last_q    <= 1'b0;
      src_ip_q     <= '0;
      src_port_q   <= '0;
      frame_ok_q   <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mac_uc_q     <= mac_uc_d;
      mac_bc_q     <= mac_bc_d;
      acc_q        <= acc_d;
      hi_q         <= hi_d;
      ip_sh_q      <= ip_sh_d;
      port_sh_q    <= port_sh_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      pl_data_q    <= pl_data_d;
      pl_valid_q   <= pl_valid_d;
      pl_last_q    <= pl_last_d;
      src_ip_q     <= src_ip_d;
      src_port_q   <= src_port_d;
      frame_ok_q   <= frame_ok_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign pl_data    = pl_data_q;
  assign pl_valid   = pl_valid_q;
  assign pl_last    = pl_last_q;
  assign src_ip     = src_ip_q;
  assign src_port   = src_port_q;
  assign frame_ok   = frame_ok_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_udp_rx_filter.sv
// Directed bench for udp_rx_filter: builds frames byte by byte and checks the
// per-byte registered response against hand-derived indices and values.
module tb_udp_rx_filter;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_last;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic        frame_ok;
  logic        frame_drop;

  udp_rx_filter #(
    .MY_MAC (48'h123456789ABC),
    .MY_IP  (32'hC0A8012C),
    .MY_PORT(16'd8000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_last   (rx_last),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_last   (pl_last),
    .src_ip    (src_ip),
    .src_port  (src_port),
    .frame_ok  (frame_ok),
    .frame_drop(frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] frm[$];
  logic [7:0] pay[$];
  logic [7:0] exp_pl[$];

  logic       r_plv [128];
  logic       r_pll [128];
  logic       r_ok  [128];
  logic       r_drop[128];
  logic [7:0] r_pld [128];
  int         r_n;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ip_csum();
    logic [31:0] s;
    s = '0;
    for (int i = 14; i < 34; i += 2) begin
      if (i != 24) s = s + {16'h0, frm[i], frm[i+1]};
    end
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [31:0] sip,
                       input logic [15:0] sport, input logic [15:0] dport,
                       input logic [15:0] ulen, input int npay, input int pad_to);
    logic [47:0] m;
    logic [15:0] tot;
    logic [15:0] cs;
    frm.delete();
    m = dmac;
    for (int i = 0; i < 6; i++) begin
      frm.push_back(m[47:40]);
      m = m << 8;
    end
    frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h45); frm.push_back(8'h00);
    tot = ulen + 16'd20;
    frm.push_back(tot[15:8]); frm.push_back(tot[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(sip[31:24]); frm.push_back(sip[23:16]);
    frm.push_back(sip[15:8]);  frm.push_back(sip[7:0]);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h01); frm.push_back(8'h2C);
    frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < npay; i++) frm.push_back(pay[i]);
    while (frm.size() < pad_to) frm.push_back(8'h00);
    cs = ip_csum();
    frm[24] = cs[15:8];
    frm[25] = cs[7:0];
  endtask

  // Response slot i holds the outputs just after the edge that consumed byte i.
  task automatic run(input int rst_idx, input int trail);
    int n;
    n   = frm.size();
    r_n = n + trail;
    for (int i = 0; i < r_n; i++) begin
      @(negedge clk);
      if (i < n) begin
        rx_valid = 1'b1;
        rx_data  = frm[i];
        rx_sof   = (i == 0);
        rx_last  = (i == n - 1);
      end else begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_sof   = 1'b0;
        rx_last  = 1'b0;
      end
      rst = (i == rst_idx);
      @(posedge clk);
      #1;
      r_plv[i]  = pl_valid;
      r_pll[i]  = pl_last;
      r_pld[i]  = pl_data;
      r_ok[i]   = frame_ok;
      r_drop[i] = frame_drop;
    end
  endtask

  task automatic check(input string tg, input int pl_first, input int last_idx,
                       input int ok_idx, input int drop_idx);
    int nplv, npll, nok, ndrop, nboth, lli, oki, dri;
    nplv = 0; npll = 0; nok = 0; ndrop = 0; nboth = 0;
    lli = -1; oki = -1; dri = -1;
    for (int i = 0; i < r_n; i++) begin
      if (r_plv[i]) nplv++;
      if (r_pll[i]) begin npll++; lli = i; end
      if (r_ok[i])  begin nok++; oki = i; end
      if (r_drop[i]) begin ndrop++; dri = i; end
      if (r_ok[i] && r_drop[i]) nboth++;
    end
    chk({tg, ".pl_count"}, longint'(nplv), longint'(exp_pl.size()));
    for (int k = 0; k < exp_pl.size(); k++) begin
      chk({tg, ".pl_valid"}, longint'(r_plv[pl_first + k]), 1);
      chk({tg, ".pl_data"}, longint'(r_pld[pl_first + k]), longint'(exp_pl[k]));
    end
    chk({tg, ".pl_last_count"}, longint'(npll), (last_idx < 0) ? 0 : 1);
    chk({tg, ".pl_last_idx"}, longint'(lli), longint'(last_idx));
    chk({tg, ".ok_count"}, longint'(nok), (ok_idx < 0) ? 0 : 1);
    chk({tg, ".ok_idx"}, longint'(oki), longint'(ok_idx));
    chk({tg, ".drop_count"}, longint'(ndrop), (drop_idx < 0) ? 0 : 1);
    chk({tg, ".drop_idx"}, longint'(dri), longint'(drop_idx));
    chk({tg, ".ok_and_drop"}, longint'(nboth), 0);
  endtask

  task automatic set_pay4();
    pay.delete();
    pay.push_back(8'hDE); pay.push_back(8'hAD); pay.push_back(8'hBE); pay.push_back(8'hEF);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0; rx_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.pl_valid",   longint'(pl_valid), 0);
    chk("reset.pl_last",    longint'(pl_last), 0);
    chk("reset.pl_data",    longint'(pl_data), 0);
    chk("reset.frame_ok",   longint'(frame_ok), 0);
    chk("reset.frame_drop", longint'(frame_drop), 0);
    chk("reset.src_ip",     longint'(src_ip), 0);
    chk("reset.src_port",   longint'(src_port), 0);
    @(negedge clk);
    rst = 1'b0;

    // Good unicast frame, udp_len 12, payload DE AD BE EF at offsets 42..45.
    set_pay4();
    build(48'h123456789ABC, 32'hC0A80101, 16'd5000, 16'd8000, 16'd12, 4, 0);
    exp_pl = pay;
    run(-1, 3);
    check("good", 42, 45, 45, -1);
    chk("good.src_ip",   longint'(src_ip), 64'hC0A80101);
    chk("good.src_port", longint'(src_port), 5000);

    // udp_len 8 padded to 60 bytes: ok after offset 41, padding never forwarded.
    build(48'h123456789ABC, 32'hC0A80101, 16'd5000, 16'd8000, 16'd8, 0, 60);
    exp_pl.delete();
    run(-1, 3);
    check("len8", 0, -1, 41, -1);

    // Corrupt IP checksum from a different sender: drop after offset 33, src_ip kept.
    build(48'h123456789ABC, 32'h0A000009, 16'd5000, 16'd8000, 16'd12, 4, 0);
    frm[24] = frm[24] ^ 8'h01;
    run(-1, 3);
    check("csum", 0, -1, -1, 33);
    chk("csum.src_ip", longint'(src_ip), 64'hC0A80101);

    // Wrong destination port, then a good frame with sof on the very next cycle.
    build(48'h123456789ABC, 32'hC0A80101, 16'd5000, 16'd8001, 16'd12, 4, 0);
    run(-1, 0);
    check("port", 0, -1, -1, 37);
    build(48'h123456789ABC, 32'hC0A80101, 16'd5001, 16'd8000, 16'd12, 4, 0);
    exp_pl = pay;
    run(-1, 3);
    check("b2b", 42, 45, 45, -1);
    chk("b2b.src_port", longint'(src_port), 5001);

    // Broadcast destination, single payload byte that also carries rx_last.
    pay.delete();
    pay.push_back(8'h5A);
    build(48'hFFFFFFFFFFFF, 32'hC0A80101, 16'd5000, 16'd8000, 16'd9, 1, 0);
    exp_pl = pay;
    run(-1, 3);
    check("bcast", 42, 42, 42, -1);

    // Wrong MAC (last byte differs): drop after offset 5.
    build(48'h123456789ABD, 32'hC0A80101, 16'd5000, 16'd8000, 16'd12, 1, 0);
    exp_pl.delete();
    run(-1, 3);
    check("mac", 0, -1, -1, 5);

    // udp_len 20 truncated by rx_last on payload byte 5.
    pay.delete();
    for (int i = 1; i <= 5; i++) pay.push_back(8'(i));
    build(48'h123456789ABC, 32'hC0A80101, 16'd5000, 16'd8000, 16'd20, 5, 0);
    exp_pl = pay;
    run(-1, 3);
    check("trunc", 42, 46, -1, 46);

    // Reset on payload byte 2: only the first payload byte escapes, no pulses.
    set_pay4();
    build(48'h123456789ABC, 32'hC0A80101, 16'd5000, 16'd8000, 16'd12, 4, 0);
    exp_pl.delete();
    exp_pl.push_back(8'hDE);
    run(43, 3);
    check("rst", 42, -1, -1, -1);
    chk("rst.src_ip",   longint'(src_ip), 0);
    chk("rst.src_port", longint'(src_port), 0);
    chk("rst.pl_data",  longint'(r_pld[43]), 0);

    exp_pl = pay;
    run(-1, 3);
    check("after_rst", 42, 45, 45, -1);
    chk("after_rst.src_ip",   longint'(src_ip), 64'hC0A80101);
    chk("after_rst.src_port", longint'(src_port), 5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
